// File: rtl/bpsk_ctrl_pkg.sv
// Shared types and constants for the BPSK transmit control path.
// Contents: frame-sequencing state enum, minimum symbol period,
// first preamble symbol value and payload byte width.
package bpsk_ctrl_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned MIN_PERIOD     = 2;
  localparam logic        PREAMBLE_START = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_TAIL     = 2'd3
  } state_e;

endpackage

// File: rtl/sym_tick_gen.sv
// Symbol-rate strobe generator: a clock enable, not a derived clock.
// Ports:
//   clk       - single clock
//   rst_n     - synchronous active-low reset
//   load      - latch period_in (clamped to MIN_PERIOD) and restart the count
//   run       - count while high; count is held at 0 while low
//   period_in - requested symbol period in clk cycles
//   sym_tick  - registered pulse on the last cycle of each period
module sym_tick_gen
  import bpsk_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] period_in,
  output logic             sym_tick
);

  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] period_clamped;
  logic             tick_q, tick_d;

  // Next count and tick; the tick flop is set when the count about to be
  // entered is the last of the period so sym_tick lines up with it.
  always_comb begin
    period_clamped = (period_in < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : period_in;
    period_d       = period_q;
    count_d        = count_q;
    tick_d         = 1'b0;
    if (load) begin
      period_d = period_clamped;
      count_d  = '0;
    end else if (run) begin
      count_d = (count_q == period_q - DIV_W'(1)) ? '0 : count_q + DIV_W'(1);
      tick_d  = (count_d == period_q - DIV_W'(1));
    end else begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period_q <= DIV_W'(MIN_PERIOD);
      count_q  <= '0;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
      tick_q   <= tick_d;
    end
  end

  assign sym_tick = tick_q;

endmodule

// File: rtl/bpsk_symbol_scheduler.sv
// Frame-level controller for the BPSK modulator: preamble, payload, tail.
// Ports:
//   Mclk, rst_n            - clock, synchronous active-low reset
//   Dclk_scale             - symbol period in Mclk cycles, latched on start
//   start                  - frame request, honoured only in IDLE
//   byte_in/last/valid     - payload byte handshake input (MSB first)
//   byte_ready             - scheduler accepts a byte this cycle
//   tx_en, phase_out       - transmit enable and current symbol value
//   sym_tick               - pulse on the last cycle of each symbol
//   busy, done, underrun   - status; underrun is sticky until next start
module bpsk_symbol_scheduler
  import bpsk_ctrl_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 8,
  parameter int unsigned TAIL_LEN     = 2,
  parameter int unsigned DIV_W        = 32
) (
  input  logic             Mclk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] Dclk_scale,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_last,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             tx_en,
  output logic             phase_out,
  output logic             sym_tick,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int unsigned SEQ_MAX = (PREAMBLE_LEN > TAIL_LEN) ? PREAMBLE_LEN : TAIL_LEN;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] PRE_LAST  = SEQ_W'(PREAMBLE_LEN - 1);
  localparam logic [SEQ_W-1:0] TAIL_LAST = SEQ_W'(TAIL_LEN - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(BYTE_W - 1);

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic                last_q, last_d;
  logic [BYTE_W-1:0]   hold_data_q, hold_data_d;
  logic                hold_last_q, hold_last_d;
  logic                hold_valid_q, hold_valid_d;
  logic                phase_q, phase_d;
  logic                tx_en_q, tx_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                underrun_q, underrun_d;
  logic                start_acc;
  logic                accept;
  logic                load_req;
  logic                go_tail;

  assign start_acc  = (state_q == ST_IDLE) && start;
  assign byte_ready = !hold_valid_q && ((state_q == ST_PREAMBLE) || (state_q == ST_DATA));
  assign accept     = byte_valid && byte_ready;

  sym_tick_gen #(
    .DIV_W (DIV_W)
  ) u_sym_tick_gen (
    .clk       (Mclk),
    .rst_n     (rst_n),
    .load      (start_acc),
    .run       (state_q != ST_IDLE),
    .period_in (Dclk_scale),
    .sym_tick  (sym_tick)
  );

  // Frame sequencing, holding register and shift register next state.
  always_comb begin
    state_d      = state_q;
    seq_d        = seq_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    last_d       = last_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    hold_valid_d = hold_valid_q;
    phase_d      = phase_q;
    underrun_d   = underrun_q;
    done_d       = 1'b0;
    load_req     = 1'b0;
    go_tail      = 1'b0;

    if (accept) begin
      hold_data_d  = byte_in;
      hold_last_d  = byte_last;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_PREAMBLE;
          seq_d      = '0;
          bit_d      = '0;
          underrun_d = 1'b0;
          phase_d    = PREAMBLE_START;
        end
      end
      ST_PREAMBLE: begin
        if (sym_tick) begin
          if (seq_q == PRE_LAST) begin
            load_req = 1'b1;
          end else begin
            seq_d   = seq_q + SEQ_W'(1);
            phase_d = !phase_q;
          end
        end
      end
      ST_DATA: begin
        if (sym_tick) begin
          if (bit_q == BIT_LAST) begin
            if (last_q) go_tail = 1'b1;
            else        load_req = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {shift_q[BYTE_W-2:0], 1'b0};
            phase_d = shift_q[BYTE_W-2];
          end
        end
      end
      ST_TAIL: begin
        if (sym_tick) begin
          if (seq_q == TAIL_LAST) begin
            state_d = ST_IDLE;
            phase_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            seq_d = seq_q + SEQ_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte load: holding register first, else a byte accepted on this very
    // edge bypasses the holding register, else the frame underruns.
    if (load_req) begin
      if (hold_valid_q) begin
        shift_d      = hold_data_q;
        last_d       = hold_last_q;
        hold_valid_d = 1'b0;
        state_d      = ST_DATA;
        bit_d        = '0;
        phase_d      = hold_data_q[BYTE_W-1];
      end else if (accept) begin
        shift_d      = byte_in;
        last_d       = byte_last;
        hold_valid_d = 1'b0;
        state_d      = ST_DATA;
        bit_d        = '0;
        phase_d      = byte_in[BYTE_W-1];
      end else begin
        underrun_d = 1'b1;
        go_tail    = 1'b1;
      end
    end

    if (go_tail) begin
      state_d = ST_TAIL;
      seq_d   = '0;
      phase_d = 1'b0;
    end

    tx_en_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge Mclk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      seq_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      phase_q      <= 1'b0;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      hold_valid_q <= hold_valid_d;
      phase_q      <= phase_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign tx_en     = tx_en_q;
  assign phase_out = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_bpsk_symbol_scheduler.sv
// Self-checking bench for bpsk_symbol_scheduler: a table of directed frames
// plus randomized frames, each compared cycle by cycle against a symbol-stream
// model built from the frame contents.
module tb_bpsk_symbol_scheduler;

  localparam int PRE  = 8;
  localparam int TAIL = 2;

  logic        Mclk;
  logic        rst_n;
  logic [31:0] Dclk_scale;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_last;
  logic        byte_valid;
  logic        byte_ready;
  logic        tx_en;
  logic        phase_out;
  logic        sym_tick;
  logic        busy;
  logic        done;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          scale;
    int          scale_after;
    int          nbytes;
    logic [31:0] data;
    bit          with_last;
    int          first_at;
    int          gap_max;
    int          exp_tx;
    int          exp_hs;
    bit          exp_und;
  } vec_t;

  vec_t vecs[7];

  bpsk_symbol_scheduler #(
    .PREAMBLE_LEN (PRE),
    .TAIL_LEN     (TAIL),
    .DIV_W        (32)
  ) dut (
    .Mclk       (Mclk),
    .rst_n      (rst_n),
    .Dclk_scale (Dclk_scale),
    .start      (start),
    .byte_in    (byte_in),
    .byte_last  (byte_last),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .tx_en      (tx_en),
    .phase_out  (phase_out),
    .sym_tick   (sym_tick),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun)
  );

  initial begin
    Mclk = 1'b0;
    forever #5 Mclk = ~Mclk;
  end

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s at %0d: got %0d expected %0d", name, cyc, act, exp_v);
    end
  endtask

  // A byte load happens at the end of the last preamble symbol and at the end
  // of every 8th data symbol after that.
  function automatic bit is_load_edge(input int e, input int p);
    int s;
    if (e % p != 0) return 1'b0;
    s = e / p;
    return (s >= PRE) && (((s - PRE) % 8) == 0);
  endfunction

  // Drives one frame from a negedge and checks every cycle up to the done
  // cycle; returns at the negedge of the cycle after done.
  task automatic run_frame(input int scale, input int scale_after, input int nbytes,
                           input logic [31:0] data, input bit with_last,
                           input int first_at, input int gap_max,
                           output int tx_cnt, output int hs_cnt);
    int   p;
    int   sym[$];
    int   t_len;
    int   data_end;
    int   next_at;
    int   idx;
    bit   hs_prev;
    bit   in_frame;
    logic [7:0] b;

    p = (scale < 2) ? 2 : scale;
    for (int i = 0; i < PRE; i++) sym.push_back((i % 2 == 0) ? 1 : 0);
    for (int j = 0; j < nbytes; j++) begin
      b = data[31 - 8*j -: 8];
      for (int k = 7; k >= 0; k--) sym.push_back(int'(b[k]));
    end
    for (int i = 0; i < TAIL; i++) sym.push_back(0);
    t_len    = sym.size() * p;
    data_end = (PRE + 8*nbytes) * p;

    start      = 1'b1;
    Dclk_scale = 32'(scale);
    byte_valid = 1'b0;
    @(negedge Mclk);
    start      = 1'b0;
    Dclk_scale = 32'(scale_after);
    idx = 0; next_at = first_at; tx_cnt = 0; hs_cnt = 0; hs_prev = 1'b0;

    for (int c = 1; c <= t_len + 1; c++) begin
      in_frame = (c <= t_len);
      chk("tx_en",     c, 32'(tx_en),     32'(in_frame));
      chk("phase_out", c, 32'(phase_out), in_frame ? 32'(sym[(c-1)/p]) : 32'd0);
      chk("sym_tick",  c, 32'(sym_tick),  32'(in_frame && (c % p == 0)));
      chk("busy",      c, 32'(busy),      32'(in_frame));
      chk("done",      c, 32'(done),      32'(c == t_len + 1));
      chk("underrun",  c, 32'(underrun),  32'(!with_last && (c > data_end)));
      if (c == 1)        chk("ready_first", c, 32'(byte_ready), 32'd1);
      if (c > data_end)  chk("ready_tail",  c, 32'(byte_ready), 32'd0);
      if (hs_prev && !is_load_edge(c - 1, p)) chk("ready_fall", c, 32'(byte_ready), 32'd0);
      if (tx_en === 1'b1) tx_cnt++;

      hs_prev = 1'b0;
      if (idx < nbytes && c >= next_at) begin
        byte_valid = 1'b1;
        byte_in    = data[31 - 8*idx -: 8];
        byte_last  = with_last && (idx == nbytes - 1);
      end else begin
        byte_valid = 1'b0;
      end
      if (byte_valid && byte_ready) begin
        hs_cnt++;
        idx++;
        hs_prev = 1'b1;
        next_at = c + 1 + int'($urandom_range(0, gap_max));
      end
      // Stray start pulses while busy must be ignored.
      start = (c < t_len) && ($urandom_range(0, 7) == 0);
      @(negedge Mclk);
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic idle_checks(input int tag, input bit exp_und);
    chk("und_sticky", tag, 32'(underrun), 32'(exp_und));
    chk("idle_busy",  tag, 32'(busy),     32'd0);
    chk("idle_tx_en", tag, 32'(tx_en),    32'd0);
    chk("idle_done",  tag, 32'(done),     32'd0);
    @(negedge Mclk);
  endtask

  initial begin
    int tx, hs, sc, sa, nb, fa, gm, p;
    bit wl;
    logic [31:0] dat;

    vecs[0] = '{4, 4, 1, 32'hA5000000, 1'b1,  2, 0,  72, 1, 1'b0};
    vecs[1] = '{0, 9, 1, 32'h5A000000, 1'b1,  2, 0,  36, 1, 1'b0};
    vecs[2] = '{1, 9, 1, 32'hE7000000, 1'b1,  3, 0,  36, 1, 1'b0};
    vecs[3] = '{3, 3, 3, 32'hFF003C00, 1'b1,  1, 0, 102, 3, 1'b0};
    vecs[4] = '{2, 2, 1, 32'h81000000, 1'b0,  2, 0,  36, 1, 1'b1};
    vecs[5] = '{3, 3, 1, 32'hC3000000, 1'b1, 24, 0,  54, 1, 1'b0};
    vecs[6] = '{2, 2, 0, 32'h00000000, 1'b0,  1, 0,  20, 0, 1'b1};

    rst_n = 1'b0; start = 1'b0; Dclk_scale = 32'd4;
    byte_in = 8'h00; byte_last = 1'b0; byte_valid = 1'b0;
    repeat (3) @(negedge Mclk);
    chk("rst_tx_en",    0, 32'(tx_en),      32'd0);
    chk("rst_phase",    0, 32'(phase_out),  32'd0);
    chk("rst_tick",     0, 32'(sym_tick),   32'd0);
    chk("rst_busy",     0, 32'(busy),       32'd0);
    chk("rst_done",     0, 32'(done),       32'd0);
    chk("rst_underrun", 0, 32'(underrun),   32'd0);
    chk("rst_ready",    0, 32'(byte_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge Mclk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].scale, vecs[i].scale_after, vecs[i].nbytes, vecs[i].data,
                vecs[i].with_last, vecs[i].first_at, vecs[i].gap_max, tx, hs);
      chk("tx_cycles",  i, 32'(tx), 32'(vecs[i].exp_tx));
      chk("handshakes", i, 32'(hs), 32'(vecs[i].exp_hs));
      idle_checks(i, vecs[i].exp_und);
      idle_checks(i, vecs[i].exp_und);
    end

    // Reset in the middle of DATA with a byte waiting in the holding register.
    start = 1'b1; Dclk_scale = 32'd2;
    @(negedge Mclk);
    start = 1'b0; byte_valid = 1'b1; byte_in = 8'h55; byte_last = 1'b0;
    repeat (19) @(negedge Mclk);
    chk("pre_reset_busy", 20, 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge Mclk);
    chk("mid_rst_tx_en",    21, 32'(tx_en),      32'd0);
    chk("mid_rst_phase",    21, 32'(phase_out),  32'd0);
    chk("mid_rst_tick",     21, 32'(sym_tick),   32'd0);
    chk("mid_rst_busy",     21, 32'(busy),       32'd0);
    chk("mid_rst_done",     21, 32'(done),       32'd0);
    chk("mid_rst_underrun", 21, 32'(underrun),   32'd0);
    chk("mid_rst_ready",    21, 32'(byte_ready), 32'd0);
    rst_n = 1'b1; byte_valid = 1'b0;
    @(negedge Mclk);
    run_frame(2, 2, 1, 32'h0F000000, 1'b1, 1, 0, tx, hs);
    chk("post_rst_tx", 0, 32'(tx), 32'd36);
    chk("post_rst_hs", 0, 32'(hs), 32'd1);
    idle_checks(100, 1'b0);

    // Randomized frames against the symbol-stream model.
    for (int r = 0; r < 12; r++) begin
      sc  = int'($urandom_range(0, 5));
      sa  = int'($urandom_range(0, 15));
      wl  = ($urandom_range(0, 3) != 0);
      nb  = wl ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 3));
      dat = $urandom;
      fa  = int'($urandom_range(1, 4));
      gm  = int'($urandom_range(0, 3));
      p   = (sc < 2) ? 2 : sc;
      run_frame(sc, sa, nb, dat, wl, fa, gm, tx, hs);
      chk("rand_tx_cycles",  r, 32'(tx), 32'((PRE + 8*nb + TAIL) * p));
      chk("rand_handshakes", r, 32'(hs), 32'(nb));
      idle_checks(200 + r, !wl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpsk_symbol_scheduler.md
# bpsk_symbol_scheduler

Frame-level controller for the BPSK modulator path. Runs entirely on `Mclk` and generates a programmable symbol-rate strobe as a clock enable, not a derived clock. Accepts payload bytes over a valid/ready handshake and sequences each frame as preamble, then payload, then tail. Drives the per-symbol phase select (`phase_out`) and the transmit enable into the modulator.

## Interface
- `PREAMBLE_LEN`, default 8: preamble symbols, alternating 1,0,… starting with 1; minimum 1.
- `TAIL_LEN`, default 2: tail symbols, all phase 0; minimum 1.
- `DIV_W`, default 32: width of the period input and the symbol counter.
- `Mclk` input 1: single clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `Dclk_scale` input DIV_W: symbol period in `Mclk` cycles; latched when `start` is accepted.
- `start` input 1: frame request; honoured only in IDLE.
- `byte_in` input 8: payload byte, sent MSB first.
- `byte_last` input 1: qualifies `byte_in` as the final payload byte.
- `byte_valid` input 1: requester has a byte.
- `byte_ready` output 1: scheduler accepts a byte this cycle.
- `tx_en` output 1: high for every cycle of every symbol.
- `phase_out` output 1: current symbol value.
- `sym_tick` output 1: one-cycle pulse on the last cycle of each symbol.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when a frame ends.
- `underrun` output 1: sticky; cleared by the next accepted `start`.

## Operation
- Every output resets to 0.
- **States:** IDLE, PREAMBLE, DATA, TAIL.
- **Period latch:** `P = max(Dclk_scale, 2)`, latched when `start` is accepted. Later changes to `Dclk_scale` have no effect until the next frame.
- **IDLE:**
  - `start` = 1 latches P, clears `underrun` and the counters, and moves to PREAMBLE.
  - `start` in any other state is ignored.
- **Symbol timer:**
  - Counts 0..P-1 and wraps to 0.
  - `sym_tick` = 1 when count = P-1.
  - Every symbol occupies exactly P cycles.
- **PREAMBLE:** sends PREAMBLE_LEN symbols. On the tick of the last preamble symbol, a byte is loaded into the shift register and the state moves to DATA.
- **DATA:** shifts one bit per symbol. On the tick of bit 7:
  - If the byte in flight was `byte_last`, go to TAIL.
  - Otherwise load the next byte and stay in DATA.
- **Holding register:** one entry.
  - `byte_ready` = busy AND holding register empty AND state ∈ {PREAMBLE, DATA}.
  - An accepted byte (valid & ready) is stored together with its `byte_last`.
  - A byte accepted on the same edge as a load tick bypasses the holding register straight into the shift register.
- **Underrun:** at a load tick with no byte available (neither holding register nor bypass), set `underrun` and go to TAIL.
- **TAIL:** sends TAIL_LEN zero symbols. On its final tick go to IDLE, then pulse `done` in the next cycle.
- **Reset mid-frame:** the next edge with `rst_n` = 0 returns everything to reset values. A held byte is discarded.

## Timing
- Call `start` sampled high at edge 0 "cycle 0".
  - Symbol k occupies cycles 1+kP .. (k+1)P.
  - `tx_en`, `busy` and `phase_out` are valid from cycle 1.
- `phase_out` changes only on the cycle after a `sym_tick`. There are no gaps between symbols.
- Frame of N bytes: `tx_en` is high for exactly (PREAMBLE_LEN + 8N + TAIL_LEN)·P cycles. `done` is high in the cycle after `tx_en` falls, with `busy` = 0 in that same cycle.
- A new `start` is legal in the same cycle `done` is high.
- `byte_ready` falls in the cycle after acceptance and rises in the cycle after the holding register drains.
- All outputs are registered. There are no combinational paths from inputs to outputs, except `byte_ready` depending on state only.

## Structure
- Shared package `bpsk_ctrl_pkg`:
  - state enum;
  - `MIN_PERIOD = 2`;
  - preamble start value;
  - `BYTE_W = 8`.
- Sub-module `sym_tick_gen` holds the period latch, the clamp, the DIV_W counter and `sym_tick`; it is reused by the receiver timing work.
- Top level holds the FSM, the holding register, the shift register, the bit counter (3 bits) and the preamble/tail counter ($clog2(max(PREAMBLE_LEN, TAIL_LEN)+1) bits).

## Test plan
- **Single byte:** `Dclk_scale`=4, one byte 0xA5 with `byte_last` → `phase_out` = 1010 1010 1010 0101 00, one symbol per 4 cycles. `tx_en` high on cycles 1–72, `done` on cycle 73, `underrun` = 0.
- **Period clamp:** `Dclk_scale`=0, and separately `Dclk_scale`=1 → `sym_tick` every 2 cycles. Change `Dclk_scale` to 9 mid-frame → period stays at 2.
- **Back-to-back bytes:** 3 bytes 0xFF, 0x00, 0x3C with `byte_valid` held high → no symbol gaps. Exactly 3 handshakes; the last has `byte_last`. `tx_en` high for 34·P cycles.
- **Underrun:** send 0x81 without `byte_last`, then withhold `byte_valid` → after 8 data symbols, `underrun` = 1, 2 tail zeros, `done`. `underrun` stays 1 until the next `start`.
- **Bypass edge:** `byte_valid` first asserted exactly on the preamble's final tick → byte loaded, no underrun, first data symbol starts the next cycle.
- **Reset and start handling:** `rst_n` low in the middle of the DATA state → all outputs 0 on the next cycle. `start` pulsed while busy → ignored, frame length unchanged.
